// File: rtl/bnn_seq_lin_layer.sv
// bnn_seq_lin_layer: sequential binary fully-connected layer.
// Evaluates N_PAR XNOR-popcount-threshold neurons per cycle, fetching the
// weights, thresholds and sign codes of one group at a time through a
// 1-cycle synchronous read port addressed by waddr_o.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   layer_i/valid_i       input feature vector and its valid (ready_o = idle)
//   waddr_o               group address to the parameter memory
//   weights_i             N_PAR weight rows returned for last cycle's address
//   threshold_i, sign_i   per-lane threshold and sign code (same timing)
//   layer_o/valid_o       output neuron bits, held until ready_i
//   score_o               per-neuron raw popcount (only with BNN_SEQ_LIN_SCORE_EN)
//
// Optional feature macro: BNN_SEQ_LIN_SCORE_EN adds the score_o port.
module bnn_seq_lin_layer #(
    parameter int unsigned ISIZE_FEAT = 288,
    parameter int unsigned OSIZE_FEAT = 64,
    parameter int unsigned N_PAR      = 8,
    parameter int unsigned N_BITCONV  = 10,
    localparam int unsigned N_GROUPS  = (OSIZE_FEAT + N_PAR - 1) / N_PAR,
    localparam int unsigned AW        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [ISIZE_FEAT-1:0]                 layer_i,
    input  logic                                  valid_i,
    output logic                                  ready_o,
    output logic [AW-1:0]                         waddr_o,
    input  logic [N_PAR-1:0][ISIZE_FEAT-1:0]      weights_i,
    input  logic [N_PAR-1:0][N_BITCONV-1:0]       threshold_i,
    input  logic [N_PAR-1:0][1:0]                 sign_i,
    output logic [OSIZE_FEAT-1:0]                 layer_o,
`ifdef BNN_SEQ_LIN_SCORE_EN
    output logic [OSIZE_FEAT-1:0][N_BITCONV-1:0]  score_o,
`endif
    output logic                                  valid_o,
    input  logic                                  ready_i
);

    localparam logic [AW-1:0] LAST_G = AW'(N_GROUPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                          state;
    logic [ISIZE_FEAT-1:0]           layer_reg;
    logic [AW-1:0]                   g;        // address being issued
    logic [AW-1:0]                   wg;       // group whose data is on the read port
    logic                            rd_pend;  // read data valid this cycle

    logic [N_PAR-1:0][N_BITCONV-1:0] lane_pc;
    logic [N_PAR-1:0]                lane_bit;
    logic [OSIZE_FEAT-1:0]           layer_nxt;

    assign waddr_o = g;

    // Per-lane XNOR-popcount and sign-coded threshold decision.
    // Codes 10/11 are constants: the bit is the inverse of sign[0].
    for (genvar l = 0; l < N_PAR; l++) begin : g_lane
        assign lane_pc[l]  = N_BITCONV'($countones(~(layer_reg ^ weights_i[l])));
        assign lane_bit[l] = (sign_i[l] == 2'b00) ? (lane_pc[l] >= threshold_i[l]) :
                             (sign_i[l] == 2'b01) ? (lane_pc[l] <  threshold_i[l]) :
                                                    ~sign_i[l][0];
    end

`ifdef BNN_SEQ_LIN_SCORE_EN
    logic [OSIZE_FEAT-1:0][N_BITCONV-1:0] score_nxt;
`endif

    // Route each lane to the neuron it owns in the returning group; lanes
    // past OSIZE_FEAT in a partial last group have no neuron and are dropped.
    for (genvar n = 0; n < OSIZE_FEAT; n++) begin : g_neuron
        localparam logic [AW-1:0]  GRP  = AW'(n / N_PAR);
        localparam int unsigned    LANE = n % N_PAR;
        logic wr;
        assign wr           = rd_pend && (wg == GRP);
        assign layer_nxt[n] = wr ? lane_bit[LANE] : layer_o[n];
`ifdef BNN_SEQ_LIN_SCORE_EN
        assign score_nxt[n] = wr ? lane_pc[LANE] : score_o[n];
`endif
    end

    // Control FSM, counters and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            layer_reg <= '0;
            g         <= '0;
            wg        <= '0;
            rd_pend   <= 1'b0;
            ready_o   <= 1'b1;
            valid_o   <= 1'b0;
            layer_o   <= '0;
`ifdef BNN_SEQ_LIN_SCORE_EN
            score_o   <= '0;
`endif
        end else begin
            rd_pend <= (state == RUN);
            layer_o <= layer_nxt;
`ifdef BNN_SEQ_LIN_SCORE_EN
            score_o <= score_nxt;
`endif
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        layer_reg <= layer_i;
                        g         <= '0;
                        wg        <= '0;
                        ready_o   <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    wg <= g;
                    if (g == LAST_G) begin
                        state <= DRAIN;
                    end else begin
                        g <= g + AW'(1);
                    end
                end
                DRAIN: begin
                    // Last group is written on this same edge.
                    valid_o <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_seq_lin_layer.sv
// Bench for bnn_seq_lin_layer: a default-size instance (64 neurons, 8 lanes)
// and a small instance with a partial last group (10 neurons, 4 lanes),
// each fed by a 1-cycle synchronous parameter memory model.
module tb_bnn_seq_lin_layer;

    localparam int unsigned IA = 288, OA = 64, PA = 8, BA = 10, GA = 8;
    localparam int unsigned IB = 16,  OB = 10, PB = 4, BB = 5,  GB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // Default-size instance
    logic [IA-1:0]          a_layer_i;
    logic                   a_valid_i, a_ready_o, a_valid_o, a_ready_i;
    logic [2:0]             a_waddr;
    logic [PA-1:0][IA-1:0]  a_w;
    logic [PA-1:0][BA-1:0]  a_t;
    logic [PA-1:0][1:0]     a_s;
    logic [OA-1:0]          a_layer_o;
    logic [PA-1:0][IA-1:0]  a_wmem [GA];
    logic [PA-1:0][BA-1:0]  a_tmem [GA];
    logic [PA-1:0][1:0]     a_smem [GA];

    // Small instance with a partial last group
    logic [IB-1:0]          b_layer_i;
    logic                   b_valid_i, b_ready_o, b_valid_o, b_ready_i;
    logic [1:0]             b_waddr;
    logic [PB-1:0][IB-1:0]  b_w;
    logic [PB-1:0][BB-1:0]  b_t;
    logic [PB-1:0][1:0]     b_s;
    logic [OB-1:0]          b_layer_o;
    logic [PB-1:0][IB-1:0]  b_wmem [4];
    logic [PB-1:0][BB-1:0]  b_tmem [4];
    logic [PB-1:0][1:0]     b_smem [4];

`ifdef BNN_SEQ_LIN_SCORE_EN
    logic [OA-1:0][BA-1:0]  a_score;
    logic [OB-1:0][BB-1:0]  b_score;
`endif

    bnn_seq_lin_layer #(.ISIZE_FEAT(IA), .OSIZE_FEAT(OA), .N_PAR(PA), .N_BITCONV(BA)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .layer_i(a_layer_i), .valid_i(a_valid_i),
        .ready_o(a_ready_o), .waddr_o(a_waddr), .weights_i(a_w), .threshold_i(a_t),
        .sign_i(a_s), .layer_o(a_layer_o),
`ifdef BNN_SEQ_LIN_SCORE_EN
        .score_o(a_score),
`endif
        .valid_o(a_valid_o), .ready_i(a_ready_i));

    bnn_seq_lin_layer #(.ISIZE_FEAT(IB), .OSIZE_FEAT(OB), .N_PAR(PB), .N_BITCONV(BB)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .layer_i(b_layer_i), .valid_i(b_valid_i),
        .ready_o(b_ready_o), .waddr_o(b_waddr), .weights_i(b_w), .threshold_i(b_t),
        .sign_i(b_s), .layer_o(b_layer_o),
`ifdef BNN_SEQ_LIN_SCORE_EN
        .score_o(b_score),
`endif
        .valid_o(b_valid_o), .ready_i(b_ready_i));

    // Synchronous-read parameter memories
    always @(posedge clk) begin
        a_w <= a_wmem[a_waddr];
        a_t <= a_tmem[a_waddr];
        a_s <= a_smem[a_waddr];
        b_w <= b_wmem[b_waddr];
        b_t <= b_tmem[b_waddr];
        b_s <= b_smem[b_waddr];
    end

    task automatic a_fill(input logic [IA-1:0] w, input logic [BA-1:0] t, input logic [1:0] s);
        for (int g = 0; g < int'(GA); g++) begin
            for (int l = 0; l < int'(PA); l++) begin
                a_wmem[g][l] = w;
                a_tmem[g][l] = t;
                a_smem[g][l] = s;
            end
        end
    endtask

    // Input handshake, then wait (bounded) for valid_o; leaves ready_i low.
    task automatic a_run(input logic [IA-1:0] x, output int lat, output bit to);
        int n;
        n = 0;
        @(negedge clk);
        while (!a_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        a_layer_i = x;
        a_valid_i = 1'b1;
        @(posedge clk);
        #1 a_valid_i = 1'b0;
        lat = 1;
        to  = 1'b0;
        while (!a_valid_o) begin
            if (lat > 100) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic a_release();
        @(negedge clk) a_ready_i = 1'b1;
        @(posedge clk);
        #1 a_ready_i = 1'b0;
    endtask

    task automatic b_run(input logic [IB-1:0] x, output int lat, output bit to);
        @(negedge clk);
        b_layer_i = x;
        b_valid_i = 1'b1;
        @(posedge clk);
        #1 b_valid_i = 1'b0;
        lat = 1;
        to  = 1'b0;
        while (!b_valid_o) begin
            if (lat > 100) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic b_release();
        @(negedge clk) b_ready_i = 1'b1;
        @(posedge clk);
        #1 b_ready_i = 1'b0;
    endtask

    // Reference for the small instance, computed neuron by neuron.
    function automatic int b_pc(input logic [IB-1:0] x, input int n);
        logic [IB-1:0] m;
        m = ~(x ^ b_wmem[n / int'(PB)][n % int'(PB)]);
        return $countones(m);
    endfunction

    function automatic logic [OB-1:0] b_gold(input logic [IB-1:0] x);
        logic [OB-1:0] r;
        int pc, th;
        r = '0;
        for (int n = 0; n < int'(OB); n++) begin
            pc = b_pc(x, n);
            th = int'(b_tmem[n / int'(PB)][n % int'(PB)]);
            case (b_smem[n / int'(PB)][n % int'(PB)])
                2'b00:   r[n] = (pc >= th);
                2'b01:   r[n] = (pc < th);
                2'b10:   r[n] = 1'b1;
                default: r[n] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_ready_o, a_valid_o, a_layer_o, a_waddr} !== {1'b1, 1'b0, 64'h0, 3'd0}) begin
            failures++;
            $display("FAIL reset_hold_a: rdy=%b vld=%b layer=%h waddr=%0d want 1 0 0 0",
                     a_ready_o, a_valid_o, a_layer_o, a_waddr);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({a_ready_o, a_valid_o, a_layer_o, a_waddr} !== {1'b1, 1'b0, 64'h0, 3'd0}) begin
            failures++;
            $display("FAIL reset_release_a: rdy=%b vld=%b layer=%h waddr=%0d want 1 0 0 0",
                     a_ready_o, a_valid_o, a_layer_o, a_waddr);
        end
        checks++;
        if ({b_ready_o, b_valid_o, b_layer_o, b_waddr} !== {1'b1, 1'b0, 10'h0, 2'd0}) begin
            failures++;
            $display("FAIL reset_release_b: rdy=%b vld=%b layer=%h waddr=%0d want 1 0 0 0",
                     b_ready_o, b_valid_o, b_layer_o, b_waddr);
        end
    endtask

    task automatic test_all_ones();
        int lat;
        bit to;
        a_fill('1, 10'd288, 2'b00);
        a_run('1, lat, to);
        checks++;
        if (to || lat != 10) begin
            failures++;
            $display("FAIL all_ones_latency: got %0d (timeout=%0b) want 10", lat, to);
        end
        checks++;
        if (a_layer_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL all_ones_layer: got %h want ffffffffffffffff", a_layer_o);
        end
`ifdef BNN_SEQ_LIN_SCORE_EN
        for (int n = 0; n < int'(OA); n++) begin
            checks++;
            if (a_score[n] !== 10'd288) begin
                failures++;
                $display("FAIL all_ones_score[%0d]: got %0d want 288", n, a_score[n]);
            end
        end
`endif
        a_release();
        checks++;
        if (a_ready_o !== 1'b1 || a_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL all_ones_release: rdy=%b vld=%b want 1 0", a_ready_o, a_valid_o);
        end
    endtask

    // Sign and threshold boundaries; each case's expected value differs from the previous one.
    task automatic test_sign_threshold();
        logic [IA-1:0] xs [5];
        logic [IA-1:0] ws [5];
        logic [BA-1:0] ts [5];
        logic [1:0]    ss [5];
        logic [OA-1:0] ex [5];
        int lat;
        bit to;
        // all-ones x/w: pc=288 ; ones x, zero w: pc=0
        xs[0] = '1; ws[0] = '1; ts[0] = 10'd288; ss[0] = 2'b01; ex[0] = '0;
        xs[1] = '1; ws[1] = '0; ts[1] = 10'd0;   ss[1] = 2'b00; ex[1] = '1;
        xs[2] = '1; ws[2] = '1; ts[2] = 10'd289; ss[2] = 2'b00; ex[2] = '0;
        xs[3] = '1; ws[3] = '0; ts[3] = 10'd1;   ss[3] = 2'b01; ex[3] = '1;
        xs[4] = '0; ws[4] = '0; ts[4] = 10'd0;   ss[4] = 2'b11; ex[4] = '0;
        for (int i = 0; i < 5; i++) begin
            a_fill(ws[i], ts[i], ss[i]);
            a_run(xs[i], lat, to);
            checks++;
            if (to || a_layer_o !== ex[i]) begin
                failures++;
                $display("FAIL sign_thr_case%0d: got %h (timeout=%0b) want %h", i, a_layer_o, to, ex[i]);
            end
            a_release();
        end
    endtask

    task automatic test_group3_force();
        int lat;
        bit to;
        a_fill('1, 10'd289, 2'b00);
        for (int l = 0; l < int'(PA); l++) a_smem[3][l] = 2'b10;
        a_run('1, lat, to);
        checks++;
        if (to || a_layer_o !== 64'h0000_0000_FF00_0000) begin
            failures++;
            $display("FAIL group3_force: got %h want 00000000ff000000", a_layer_o);
        end
        a_release();
    endtask

    task automatic test_partial_group();
        logic [IB-1:0] x;
        logic [OB-1:0] ex;
        int lat;
        bit to;
        for (int r = 0; r < 4; r++) begin
            for (int g = 0; g < 4; g++) begin
                for (int l = 0; l < int'(PB); l++) begin
                    b_wmem[g][l] = IB'($urandom);
                    b_tmem[g][l] = BB'($urandom_range(4, 13));
                    b_smem[g][l] = (r == 0) ? 2'(l % 4) : 2'($urandom_range(0, 1));
                end
            end
            // lanes 2..3 of group 2 have no neuron; force them to "1" codes
            b_smem[2][2] = 2'b10;
            b_smem[2][3] = 2'b10;
            x  = IB'($urandom);
            ex = b_gold(x);
            b_run(x, lat, to);
            checks++;
            if (to || lat != 5) begin
                failures++;
                $display("FAIL partial_latency_r%0d: got %0d (timeout=%0b) want 5", r, lat, to);
            end
            checks++;
            if (b_layer_o !== ex) begin
                failures++;
                $display("FAIL partial_layer_r%0d: got %h want %h", r, b_layer_o, ex);
            end
`ifdef BNN_SEQ_LIN_SCORE_EN
            for (int n = 0; n < int'(OB); n++) begin
                checks++;
                if (int'(b_score[n]) != b_pc(x, n)) begin
                    failures++;
                    $display("FAIL partial_score_r%0d[%0d]: got %0d want %0d", r, n, b_score[n], b_pc(x, n));
                end
            end
`endif
            b_release();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        a_fill('1, 10'd288, 2'b00);
        a_run('1, lat, to);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a_valid_i = (c % 3 == 0);
            a_layer_i = '0;
            @(posedge clk);
            #1;
            checks++;
            if (a_valid_o !== 1'b1 || a_ready_o !== 1'b0 || a_layer_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                failures++;
                $display("FAIL backpressure_c%0d: vld=%b rdy=%b layer=%h want 1 0 ffffffffffffffff",
                         c, a_valid_o, a_ready_o, a_layer_o);
            end
        end
        a_valid_i = 1'b0;
        a_release();
        checks++;
        if (a_ready_o !== 1'b1 || a_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: rdy=%b vld=%b want 1 0", a_ready_o, a_valid_o);
        end
        // zero input against all-ones weights: pc=0 < 288, so all zeros
        a_run('0, lat, to);
        checks++;
        if (to || lat != 10 || a_layer_o !== 64'h0) begin
            failures++;
            $display("FAIL backpressure_next: layer=%h lat=%0d want 0 lat 10", a_layer_o, lat);
        end
        a_release();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        a_fill('1, 10'd288, 2'b00);
        a_run('1, lat, to);
        a_release();
        // start a second operation, then reset while group 4 is being written
        @(negedge clk);
        a_layer_i = '1;
        a_valid_i = 1'b1;
        @(posedge clk);
        #1 a_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ready_o, a_valid_o, a_layer_o, a_waddr} !== {1'b1, 1'b0, 64'h0, 3'd0}) begin
            failures++;
            $display("FAIL reset_mid_async: rdy=%b vld=%b layer=%h waddr=%0d want 1 0 0 0",
                     a_ready_o, a_valid_o, a_layer_o, a_waddr);
        end
`ifdef BNN_SEQ_LIN_SCORE_EN
        checks++;
        if (a_score !== '0) begin
            failures++;
            $display("FAIL reset_mid_score: score not cleared");
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        a_run('1, lat, to);
        checks++;
        if (to || lat != 10 || a_layer_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL reset_mid_rerun: layer=%h lat=%0d want ffffffffffffffff lat 10", a_layer_o, lat);
        end
        a_release();
    endtask

    initial begin
        a_layer_i = '0; a_valid_i = 1'b0; a_ready_i = 1'b0;
        b_layer_i = '0; b_valid_i = 1'b0; b_ready_i = 1'b0;
        a_fill('0, '0, 2'b11);
        for (int g = 0; g < 4; g++) begin
            for (int l = 0; l < int'(PB); l++) begin
                b_wmem[g][l] = '0;
                b_tmem[g][l] = '0;
                b_smem[g][l] = 2'b11;
            end
        end
        test_reset();
        test_all_ones();
        test_sign_threshold();
        test_group3_force();
        test_partial_group();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
